// File: rtl/spm_bcd_converter.sv
// Sequential double-dabble converter: signed SPM product -> sign-magnitude packed BCD.
// Optional leading-zero blanking mask is built only when BCD_BLANK_EN is defined.
module spm_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      prod,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Decimal digits needed for the largest magnitude, 2**(WIDTH-1).
  function automatic int dec_digits(input int w);
    longint v;
    int     n;
    v = longint'(1) << (w - 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v > 64'sd0) begin
        v = v / 64'sd10;
        n = n + 1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  if (DIGITS < dec_digits(WIDTH)) begin : g_digits_check
    $error("spm_bcd_converter: DIGITS too small for WIDTH");
  end

`ifdef BCD_BLANK_EN
  function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] v);
    logic              z;
    logic [DIGITS-1:0] m;
    z = 1'b1;
    m = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z    = z & (v[4*i +: 4] == 4'd0);
      m[i] = z & (i != 0);
    end
    return m;
  endfunction
`endif

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    mag_q;
  logic [4*DIGITS-1:0] scratch_q;
  logic                sign_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                neg_q;
  logic                busy_q;
  logic                done_q;
  logic [DIGITS-1:0]   blank_q;

  logic [4*DIGITS-1:0] adj_d;
  logic [4*DIGITS-1:0] scratch_d;
  logic [WIDTH-1:0]    mag_d;
  logic [WIDTH-1:0]    load_mag_d;
  logic [DIGITS-1:0]   blank_d;

  // One double-dabble iteration plus the magnitude of the incoming product.
  always_comb begin
    adj_d = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        adj_d[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end else begin
        adj_d[4*d +: 4] = scratch_q[4*d +: 4];
      end
    end
    scratch_d = {adj_d[4*DIGITS-2:0], mag_q[WIDTH-1]};
    mag_d     = {mag_q[WIDTH-2:0], 1'b0};
    // Two's-complement negate; the most negative value wraps to 2**(WIDTH-1) unsigned.
    if (prod[WIDTH-1]) begin
      load_mag_d = ~prod + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      load_mag_d = prod;
    end
`ifdef BCD_BLANK_EN
    blank_d = blank_mask(scratch_d);
`else
    blank_d = '0;
`endif
  end

  // Control FSM with registered result and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      blank_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            mag_q     <= load_mag_d;
            sign_q    <= prod[WIDTH-1];
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_CONVERT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CONVERT: begin
          scratch_q <= scratch_d;
          mag_q     <= mag_d;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            bcd_q   <= scratch_d;
            neg_q   <= sign_q;
            blank_q <= blank_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_CONVERT;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bcd   = bcd_q;
  assign neg   = neg_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_spm_bcd_converter.sv
// Directed + random bench for spm_bcd_converter against a divide/modulo decimal reference.
module tb_spm_bcd_converter;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [15:0] prod;
  logic [19:0]        bcd;
  logic               neg;
  logic               busy;
  logic               done;
  logic [4:0]         blank;

  int errors = 0;
  int checks = 0;
  logic [19:0] last_bcd;

  spm_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .prod(prod),
    .bcd(bcd), .neg(neg), .busy(busy), .done(done), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    int m, p;
    logic [19:0] r;
    m = (v < 0) ? -v : v;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int v);
    logic [4:0] r;
    int m, p;
    r = 5'b0;
    m = (v < 0) ? -v : v;
    p = 10;
`ifdef BCD_BLANK_EN
    for (int i = 1; i < 5; i++) begin
      r[i] = (m < p);
      p = p * 10;
    end
`endif
    return r;
  endfunction

  task automatic run_conv(input logic signed [15:0] p, input string tag);
    int cyc;
    int v;
    v = p;
    @(negedge clk); start = 1'b1; prod = p;
    @(posedge clk); #1; start = 1'b0;
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    do begin
      prod = 16'($urandom);
      @(posedge clk); #1; cyc++;
      if (cyc == 8) chk({tag, " hold"}, {12'd0, bcd}, {12'd0, last_bcd});
    end while (!done && cyc < 40);
    chk({tag, " latency"}, cyc, 32'd16);
    chk({tag, " bcd"}, {12'd0, bcd}, {12'd0, ref_bcd(v)});
    chk({tag, " neg"}, {31'd0, neg}, {31'd0, v < 0});
    chk({tag, " blank"}, {27'd0, blank}, {27'd0, ref_blank(v)});
    chk({tag, " busy_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " pulse"}, {31'd0, done}, 32'd0);
    last_bcd = ref_bcd(v);
  endtask

  initial begin
    int ndone;
    logic [19:0] cap;
    rst = 1'b0; start = 1'b1; prod = 16'sd120;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst bcd", {12'd0, bcd}, 32'd0);
      chk("rst flags", {29'd0, neg, busy, done}, 32'd0);
      chk("rst blank", {27'd0, blank}, 32'd0);
    end
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("post rst idle", {30'd0, busy, done}, 32'd0);
    last_bcd = 20'h0;

    run_conv(16'sd120, "p120");
    run_conv(-16'sd1000, "m1000");
    run_conv(-16'sd32768, "m32768");
    run_conv(16'sd0, "zero");
    run_conv(16'sd32767, "max");
    run_conv(-16'sd1, "m1");

    // Start requests during CONVERT and DONE must be ignored.
    @(negedge clk); start = 1'b1; prod = 16'sd64;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0; cap = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; cap = bcd; end
      if (c == 4)  begin start = 1'b1; prod = -16'sd5; end
      if (c == 5)  start = 1'b0;
      if (c == 16) begin start = 1'b1; prod = -16'sd5; end
      if (c == 17) start = 1'b0;
    end
    chk("ignore ndone", ndone, 32'd1);
    chk("ignore bcd", {12'd0, cap}, {12'd0, ref_bcd(64)});
    chk("ignore neg", {31'd0, neg}, 32'd0);

    // Reset in the middle of a conversion discards it.
    @(negedge clk); start = 1'b1; prod = 16'sd777;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    chk("midrst bcd", {12'd0, bcd}, 32'd0);
    chk("midrst flags", {29'd0, neg, busy, done}, 32'd0);
    chk("midrst blank", {27'd0, blank}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("midrst quiet", ndone, 32'd0);
    last_bcd = 20'h0;

    // Products as an upstream SPM would deliver them.
    run_conv(-16'sd128, "spm m128x1");
    run_conv(-16'sd1000, "spm m100x10");

    for (int i = 0; i < 20; i++) begin
      run_conv(16'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
